// File: rtl/layers_sched_pkg.sv
// Shared definitions for the layers scheduler: cfg bus addresses, FSM
// state encoding and the window-length normalisation helper.
package layers_sched_pkg;

    // Cfg bus register addresses. CFG_LAYERS belongs to the layers block and
    // is only snooped here for the pooling factor.
    localparam logic [4:0] CFG_LAYERS    = 5'd2;
    localparam logic [4:0] CFG_SCHED_WIN = 5'd20;
    localparam logic [4:0] CFG_SCHED_OUT = 5'd21;
    localparam logic [4:0] CFG_SCHED_GO  = 5'd22;

    // One-hot pass sequencing states.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } sched_state_t;

    // A window of zero beats makes no sense; treat it as a single beat.
    function automatic logic [15:0] eff_win(input logic [15:0] win);
        return (win == 16'd0) ? 16'd1 : win;
    endfunction

endpackage

// File: rtl/layers_sched_if.sv
// Bundle of the scheduler's cfg, image stream, kernel address and result
// snoop signals. master = surrounding datapath/environment, slave = scheduler.
interface layers_sched_if #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int GROUP_NB   = 4,
    parameter int IMG_WIDTH  = 16
);
    logic [CFG_DWIDTH-1:0]         cfg_data;
    logic [CFG_AWIDTH-1:0]         cfg_addr;
    logic                          cfg_valid;
    logic [GROUP_NB*IMG_WIDTH-1:0] src_bus;
    logic                          src_val;
    logic                          src_rdy;
    logic [GROUP_NB*IMG_WIDTH-1:0] image_bus;
    logic                          image_last;
    logic                          image_val;
    logic                          image_rdy;
    logic [15:0]                   ker_addr;
    logic                          res_val;
    logic                          res_rdy;
    logic                          busy;
    logic                          done;

    modport master (
        output cfg_data, cfg_addr, cfg_valid, src_bus, src_val, image_rdy,
               res_val, res_rdy,
        input  src_rdy, image_bus, image_last, image_val, ker_addr, busy, done
    );

    modport slave (
        input  cfg_data, cfg_addr, cfg_valid, src_bus, src_val, image_rdy,
               res_val, res_rdy,
        output src_rdy, image_bus, image_last, image_val, ker_addr, busy, done
    );
endinterface

// File: rtl/layers_sched_cnt.sv
// Wrapping counter with programmable terminal value. wrap pulses on the
// enabled cycle in which the count sits at term; the count then returns to 0.
module layers_sched_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    logic [WIDTH-1:0] count_reg;

    assign wrap  = en & (count_reg == term);
    assign count = count_reg;

    // Count enabled events, folding back to zero after the terminal value.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= wrap ? '0 : count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/layers_sched.sv
// Convolution pass sequencer: forwards image beats to the layers block,
// marks the last beat of each MAC window, drives the kernel beat address
// and waits for the configured number of pooled results.
module layers_sched
    import layers_sched_pkg::*;
(
    input logic           clk,
    input logic           rst,
    layers_sched_if.slave bus
);
    sched_state_t state_reg, state_next;

    // Cfg shadow registers (written any time) and the values latched at start.
    logic [15:0] win_cfg_reg, out_cfg_reg;
    logic [7:0]  pool_cfg_reg;
    logic [15:0] win_term_reg, out_nb_reg;
    logic [23:0] total_term_reg;
    logic [15:0] res_cnt_reg;

    logic        start, in_run, in_drain, xfer;
    logic        beat_wrap, last_win, res_hs, res_full, res_last;
    logic [15:0] beat_cnt;
    logic [23:0] win_cnt, total_win;

    // Only a GO seen in IDLE starts a pass; GO in any other state is dropped.
    assign start    = bus.cfg_valid && (bus.cfg_addr == CFG_SCHED_GO) && (state_reg == ST_IDLE);
    assign in_run   = (state_reg == ST_RUN);
    assign in_drain = (state_reg == ST_DRAIN);
    assign xfer     = in_run & bus.src_val & bus.image_rdy;

    // Windows per pass = outputs * (pool_nb + 1), kept to 24 bits.
    assign total_win = {8'd0, out_cfg_reg} * {15'd0, ({1'b0, pool_cfg_reg} + 9'd1)};

    layers_sched_cnt #(.WIDTH(16)) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (xfer),
        .term  (win_term_reg),
        .count (beat_cnt),
        .wrap  (beat_wrap)
    );

    layers_sched_cnt #(.WIDTH(24)) u_win_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (beat_wrap),
        .term  (total_term_reg),
        .count (win_cnt),
        .wrap  (last_win)
    );

    // Result snoop; the final result may arrive in the same cycle DRAIN is left.
    assign res_hs   = bus.res_val & bus.res_rdy & (in_run | in_drain);
    assign res_full = (res_cnt_reg == out_nb_reg);
    assign res_last = res_full | (res_hs & ((res_cnt_reg + 16'd1) == out_nb_reg));

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = (out_cfg_reg == 16'd0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (last_win) state_next = ST_DRAIN;
            ST_DRAIN: if (res_last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, cfg shadows, start-time snapshot and saturating result count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            win_cfg_reg    <= '0;
            out_cfg_reg    <= '0;
            pool_cfg_reg   <= '0;
            win_term_reg   <= '0;
            out_nb_reg     <= '0;
            total_term_reg <= '0;
            res_cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (bus.cfg_valid) begin
                if (bus.cfg_addr == CFG_SCHED_WIN) win_cfg_reg  <= bus.cfg_data[15:0];
                if (bus.cfg_addr == CFG_SCHED_OUT) out_cfg_reg  <= bus.cfg_data[15:0];
                if (bus.cfg_addr == CFG_LAYERS)    pool_cfg_reg <= bus.cfg_data[15:8];
            end
            if (start) begin
                win_term_reg   <= eff_win(win_cfg_reg) - 16'd1;
                out_nb_reg     <= out_cfg_reg;
                total_term_reg <= total_win - 24'd1;
                res_cnt_reg    <= '0;
            end else if (res_hs && !res_full) begin
                res_cnt_reg <= res_cnt_reg + 16'd1;
            end
        end
    end

    assign bus.image_bus  = bus.src_bus;
    assign bus.image_val  = bus.src_val & in_run;
    assign bus.src_rdy    = bus.image_rdy & in_run;
    assign bus.image_last = in_run & (beat_cnt == win_term_reg);
    assign bus.ker_addr   = beat_cnt;
    assign bus.busy       = in_run | in_drain;
    assign bus.done       = (state_reg == ST_DONE);
endmodule

// File: tb/tb_layers_sched.sv
// Self-checking bench for layers_sched: directed passes plus randomized
// passes with random handshakes and cfg traffic, checked against a
// beat-index model of the pass.
module tb_layers_sched;
    import layers_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layers_sched_if bus ();

    layers_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic idle_inputs();
        bus.cfg_valid = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.src_val   = 1'b0;
        bus.src_bus   = '0;
        bus.image_rdy = 1'b0;
        bus.res_val   = 1'b0;
        bus.res_rdy   = 1'b0;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        idle_inputs();
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_data  = d;
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
    endtask

    // One full pass: program, GO, then cycle with random handshakes while the
    // model tracks the accepted-beat index k and the result count r.
    task automatic run_pass(input int win, input int pool, input int outn,
                            input int vprob, input int rprob, input int resprob,
                            input bit noise);
        int weff, nbeats, k, r, phase, cyc, rp;
        bit hold, acc;
        logic [31:0] d;
        weff   = (win == 0) ? 1 : win;
        nbeats = outn * (pool + 1) * weff;
        d = $urandom; d[15:0] = 16'(win);
        cfg_write(CFG_SCHED_WIN, d);
        d = $urandom; d[15:0] = 16'(outn);
        cfg_write(CFG_SCHED_OUT, d);
        d = $urandom; d[15:8] = 8'(pool);
        cfg_write(CFG_LAYERS, d);
        cfg_write(CFG_SCHED_GO, $urandom);
        $display("pass win=%0d pool=%0d out=%0d beats=%0d", win, pool, outn, nbeats);
        k = 0; r = 0; cyc = 0; hold = 1'b0;
        phase = (outn == 0) ? 3 : 1;   // 1 run, 2 drain, 3 done
        while (phase != 3 && cyc < 3000) begin
            @(negedge clk);
            if (!hold) begin
                bus.src_val = (int'($urandom_range(99)) < vprob);
                bus.src_bus = {$urandom, $urandom};
            end
            bus.image_rdy = (int'($urandom_range(99)) < rprob);
            rp = (phase == 2 && resprob < 40) ? 40 : resprob;
            bus.res_val = (int'($urandom_range(99)) < rp);
            bus.res_rdy = ($urandom_range(3) != 0);
            bus.cfg_valid = noise && ($urandom_range(99) < 15);
            case ($urandom_range(3))
                0: bus.cfg_addr = CFG_SCHED_WIN;
                1: bus.cfg_addr = CFG_SCHED_OUT;
                2: bus.cfg_addr = CFG_LAYERS;
                default: bus.cfg_addr = CFG_SCHED_GO;
            endcase
            bus.cfg_data = $urandom;
            #1;
            check("busy", bus.busy, 1);
            check("done_early", bus.done, 0);
            check("image_val", bus.image_val, bus.src_val && phase == 1);
            check("src_rdy", bus.src_rdy, bus.image_rdy && phase == 1);
            check("image_last", bus.image_last, phase == 1 && (k % weff) == weff - 1);
            check("ker_addr", bus.ker_addr, k % weff);
            check("image_bus", bus.image_bus, bus.src_bus);
            if (bus.image_val && bus.src_rdy)
                $display("  beat k=%0d ker_addr=%0d last=%0b", k, bus.ker_addr, bus.image_last);
            acc  = (phase == 1) && bus.src_val && bus.image_rdy;
            hold = bus.src_val && !acc;
            if (bus.res_val && bus.res_rdy && r < outn) r++;
            if (phase == 1) begin
                if (acc) begin
                    k++;
                    if (k == nbeats) phase = 2;
                end
            end else if (phase == 2 && r == outn) begin
                phase = 3;
            end
            cyc++;
        end
        if (phase != 3) check("pass_timeout", 0, 1);
        // DONE cycle: a GO here must be ignored, image path must be closed.
        @(negedge clk);
        idle_inputs();
        bus.src_val = 1'b1; bus.image_rdy = 1'b1;
        bus.cfg_valid = 1'b1; bus.cfg_addr = CFG_SCHED_GO;
        #1;
        check("done_pulse", bus.done, 1);
        check("busy_at_done", bus.busy, 0);
        check("src_rdy_at_done", bus.src_rdy, 0);
        check("image_val_at_done", bus.image_val, 0);
        check("ker_addr_at_done", bus.ker_addr, 0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        #1;
        check("done_one_cycle", bus.done, 0);
        check("idle_after_done", bus.busy, 0);
        check("src_rdy_idle", bus.src_rdy, 0);
        $display("pass end cycles=%0d results=%0d", cyc, r);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.src_val = 1'b1; bus.image_rdy = 1'b1;
        #1;
        check("rst_src_rdy", bus.src_rdy, 0);
        check("rst_image_val", bus.image_val, 0);
        check("rst_image_last", bus.image_last, 0);
        check("rst_ker_addr", bus.ker_addr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        idle_inputs();

        run_pass(4, 0, 2, 100, 100, 0, 1'b0);
        run_pass(3, 1, 1, 100, 50, 30, 1'b0);
        run_pass(5, 2, 0, 100, 100, 30, 1'b0);
        run_pass(0, 0, 3, 70, 70, 30, 1'b0);
        for (int i = 0; i < 12; i++)
            run_pass($urandom_range(5), $urandom_range(2), $urandom_range(3),
                     $urandom_range(40, 100), $urandom_range(30, 100),
                     $urandom_range(0, 60), 1'b1);

        // Reset in the middle of a pass, then restart from a clean state.
        cfg_write(CFG_SCHED_WIN, 32'd4);
        cfg_write(CFG_SCHED_OUT, 32'd2);
        cfg_write(CFG_LAYERS, 32'd0);
        cfg_write(CFG_SCHED_GO, 32'd0);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            bus.src_val = 1'b1; bus.image_rdy = 1'b1;
            bus.src_bus = {$urandom, $urandom};
            #1;
            check("midrst_ker_addr", bus.ker_addr, b);
            if (b == 2) rst = 1'b1;
        end
        @(negedge clk);
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_image_val", bus.image_val, 0);
        check("midrst_src_rdy", bus.src_rdy, 0);
        check("midrst_ker_addr0", bus.ker_addr, 0);
        rst = 1'b0;
        idle_inputs();
        run_pass(4, 0, 2, 100, 100, 20, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
